// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: state encoding and
// the default iteration count.
package mul_div_unit_pkg;

  localparam int unsigned MDU_ITER = 32;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2,
    MDU_FIX  = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_div_iter.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference when it does not borrow.
module mdu_div_iter
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned DW = MDU_ITER
) (
  input  logic [DW:0]   rem_i,
  input  logic          dvd_msb_i,
  input  logic [DW-1:0] dvs_i,
  output logic [DW:0]   rem_o,
  output logic          qbit_o
);

  logic [DW+1:0] shifted;
  logic [DW+1:0] diff;

  // One extra bit above the shifted remainder so the MSB of diff is the borrow.
  assign shifted = {rem_i, dvd_msb_i};
  assign diff    = shifted - {2'b00, dvs_i};
  assign qbit_o  = ~diff[DW+1];
  assign rem_o   = qbit_o ? diff[DW:0] : shifted[DW:0];

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit working on operand magnitudes with a
// final sign-fix state. Define MDU_FAST_MUL_EN for a single-cycle multiply.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned DW = MDU_ITER
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          mult,
  input  logic          div,
  input  logic          mdsign,
  input  logic [DW-1:0] rega,
  input  logic [DW-1:0] regb,
  input  logic          flush,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] hi,
  output logic [DW-1:0] lo
);

  localparam int unsigned CW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  function automatic logic [DW-1:0] mag(input logic [DW-1:0] x, input logic sgn);
    return (sgn && x[DW-1]) ? ('0 - x) : x;
  endfunction

  mdu_state_e       state_q, state_d;
  logic [DW-1:0]    a_q, a_d, b_q, b_d, quo_q, quo_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*DW-1:0]  acc_q, acc_d;
  logic [DW:0]      rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             negq_q, negq_d, negr_q, negr_d, op_mul_q, op_mul_d;
  logic             busy_q, done_q, done_d;

  logic [DW-1:0]    mag_a, mag_b;
  logic [DW:0]      mul_sum;
  logic [DW:0]      div_rem;
  logic             div_qbit;
  logic [2*DW-1:0]  prod_fix;
  logic [DW-1:0]    quo_fix, rem_fix, fix_hi, fix_lo;

  mdu_div_iter #(.DW(DW)) u_div_iter (
    .rem_i     (rem_q),
    .dvd_msb_i (quo_q[DW-1]),
    .dvs_i     (b_q),
    .rem_o     (div_rem),
    .qbit_o    (div_qbit)
  );

  assign mag_a   = mag(rega, mdsign);
  assign mag_b   = mag(regb, mdsign);
  assign mul_sum = {1'b0, acc_q[2*DW-1:DW]} + (b_q[0] ? {1'b0, a_q} : '0);

  assign prod_fix = negq_q ? ('0 - acc_q) : acc_q;
  assign quo_fix  = negq_q ? ('0 - quo_q) : quo_q;
  assign rem_fix  = negr_q ? ('0 - rem_q[DW-1:0]) : rem_q[DW-1:0];
  assign fix_hi   = op_mul_q ? prod_fix[2*DW-1:DW] : rem_fix;
  assign fix_lo   = op_mul_q ? prod_fix[DW-1:0] : quo_fix;

  // done_q is high exactly in FIX; the fixed result is shown that cycle and
  // committed to hi_q/lo_q on its closing edge unless flushed.
  assign busy = busy_q;
  assign done = done_q;
  assign hi   = done_q ? fix_hi : hi_q;
  assign lo   = done_q ? fix_lo : lo_q;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    op_mul_d = op_mul_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    if (flush) begin
      state_d = MDU_IDLE;
    end else begin
      unique case (state_q)
        MDU_IDLE: begin
          if (start && (mult || div)) begin
            a_d      = mag_a;
            b_d      = mag_b;
            quo_d    = mag_a;
            rem_d    = '0;
            acc_d    = '0;
            cnt_d    = '0;
            negq_d   = mdsign & (rega[DW-1] ^ regb[DW-1]);
            negr_d   = mdsign & rega[DW-1];
            op_mul_d = mult;
            if (mult) begin
`ifdef MDU_FAST_MUL_EN
              acc_d   = (2*DW)'(mag_a) * (2*DW)'(mag_b);
              state_d = MDU_FIX;
              done_d  = 1'b1;
`else
              state_d = MDU_MUL;
`endif
            end else begin
              state_d = MDU_DIV;
            end
          end
        end
        MDU_MUL: begin
          acc_d = {mul_sum, acc_q[DW-1:1]};
          b_d   = b_q >> 1;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d = MDU_FIX;
            done_d  = 1'b1;
          end
        end
        MDU_DIV: begin
          rem_d = div_rem;
          quo_d = {quo_q[DW-2:0], div_qbit};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d = MDU_FIX;
            done_d  = 1'b1;
          end
        end
        MDU_FIX: begin
          hi_d    = fix_hi;
          lo_d    = fix_lo;
          state_d = MDU_IDLE;
        end
        default: state_d = MDU_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= MDU_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      op_mul_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      op_mul_q <= op_mul_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= (state_d != MDU_IDLE);
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table, random ops against a
// reference model, and flush / async-reset / held-start sequences.
module tb_mul_div_unit;

  localparam int DIV_LAT = 33;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        resetn, start, mult, div, mdsign, flush;
  logic [31:0] rega, regb;
  logic        busy, done;
  logic [31:0] hi, lo;

  mul_div_unit #(.DW(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .mult   (mult),
    .div    (div),
    .mdsign (mdsign),
    .rega   (rega),
    .regb   (regb),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          scyc;
  } exp_t;

  typedef struct {
    logic        m;
    logic        d;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  exp_t        sb[$];
  vec_t        vt[13];
  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  int          exp_cnt = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] eh, input logic [31:0] el, input int lat);
    exp_t e;
    e.hi = eh; e.lo = el; e.lat = lat; e.scyc = cyc;
    sb.push_back(e);
    exp_cnt++;
  endtask

  always @(negedge clk) begin
    if (resetn && done) begin
      exp_t e;
      done_cnt++;
      chk("sb_nonempty", 64'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("res_hi", hi, e.hi);
        chk("res_lo", lo, e.lo);
        chk("latency", 64'(cyc - e.scyc), 64'(e.lat));
      end
    end
  end

  function automatic logic [63:0] model(input logic m, input logic s,
                                        input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] q, r;
    if (m) begin
      if (s) return $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      return {32'b0, a} * {32'b0, b};
    end
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Called at a negedge with the unit idle; returns at a negedge one cycle after done.
  task automatic run(input logic m, input logic d, input logic s, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int   n;
    logic ok;
    start = 1'b1; mult = m; div = d; mdsign = s; rega = a; regb = b;
    chk("busy_c0", busy, 0);
    push(eh, el, m ? MUL_LAT : DIV_LAT);
    @(negedge clk);
    start = 1'b0; mult = 1'b0; div = 1'b0;
    mdsign = 1'($urandom_range(0, 1)); rega = $urandom; regb = $urandom;
    n = 1; ok = 1'b1;
    while (!done && n < 60) begin
      if (!busy) ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
    chk("busy_run", ok, 1);
    @(negedge clk);
    chk("busy_after", busy, 0);
    chk("done_pulse", done, 0);
    chk("hold_hi", hi, eh);
    chk("hold_lo", lo, el);
    last_hi = eh; last_lo = el;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic        m, s;
    logic [31:0] a, b;
    logic [63:0] r;

    vt[0]  = '{1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vt[1]  = '{1, 0, 1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vt[2]  = '{0, 1, 1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[3]  = '{0, 1, 0, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
    vt[4]  = '{0, 1, 0, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
    vt[5]  = '{0, 1, 1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vt[6]  = '{0, 1, 1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vt[7]  = '{0, 1, 1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
    vt[8]  = '{0, 1, 1, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'h00000001};
    vt[9]  = '{1, 0, 1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vt[10] = '{1, 0, 1, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F};
    vt[11] = '{1, 0, 0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vt[12] = '{1, 1, 1, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};

    resetn = 1'b0; start = 1'b0; mult = 1'b0; div = 1'b0; mdsign = 1'b0;
    rega = '0; regb = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++)
      run(vt[i].m, vt[i].d, vt[i].s, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo);

    for (int i = 0; i < 8; i++) begin
      m = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      if (!m && b == 0) b = 32'd1;
      if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
      r = model(m, s, a, b);
      run(m, !m, s, a, b, r[63:32], r[31:0]);
    end

    // Flush mid-divide: no result, outputs hold, restart the very next cycle.
    start = 1'b1; div = 1'b1; mdsign = 1'b0; rega = 32'd100; regb = 32'd7;
    @(negedge clk);
    start = 1'b0; div = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_done", done, 0);
    chk("flush_hi", hi, last_hi);
    chk("flush_lo", lo, last_lo);
    run(0, 1, 0, 32'd100, 32'd7, 32'd2, 32'd14);

    // Asynchronous reset in the middle of a divide.
    start = 1'b1; div = 1'b1; mdsign = 1'b1; rega = 32'd1000; regb = 32'd3;
    @(negedge clk);
    start = 1'b0; div = 1'b0;
    repeat (19) @(negedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // start held high across the whole operation must produce one done only.
    start = 1'b1; div = 1'b1; mdsign = 1'b0; rega = 32'd1000; regb = 32'd3;
    push(32'd1, 32'd333, DIV_LAT);
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("held_done", done, 1);
    start = 1'b0; div = 1'b0;
    repeat (40) @(negedge clk);
    chk("held_idle", busy, 0);
    chk("held_lo", lo, 32'd333);

    chk("done_count", 64'(done_cnt), 64'(exp_cnt));
    chk("sb_empty", 64'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
